// File: rtl/skein_pkg.sv
// Shared types and helpers for the skein512 result path (hit filter, share reporting).
package skein_pkg;

    typedef logic [511:0] skein_hash_t;
    typedef logic [31:0]  skein_nonce_t;

    localparam int SKEIN_NONCE_LAG_DEFAULT = 38;

    // Recovers the nonce that produced the hash currently at skein512's output.
    function automatic skein_nonce_t nonce_origin(input skein_nonce_t nonce, input int unsigned lag);
        return nonce - skein_nonce_t'(lag);
    endfunction

endpackage

// File: rtl/skein_hit_fifo.sv
// Synchronous FIFO with a first-word-fall-through head taken straight from the entry registers.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module skein_hit_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Stale entries stay in mem after a reset, so the head is forced to zero when empty.
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/skein_hit_filter.sv
// Flags skein512 results whose top word is below target and queues their origin nonces.
// Define HIT_HASH_CAPTURE_EN to store the full hash with each hit and expose it on out_hash.
module skein_hit_filter
    import skein_pkg::*;
#(
    parameter int NONCE_LAG  = SKEIN_NONCE_LAG_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [63:0]  target,
    input  logic         hash_vld,
    input  skein_hash_t  hash,
    input  skein_nonce_t nonce,
    output logic [31:0]  hit_cnt,
    output logic         overflow,
    output logic         out_vld,
    input  logic         out_rdy,
    output skein_nonce_t out_nonce
`ifdef HIT_HASH_CAPTURE_EN
    ,
    output skein_hash_t  out_hash
`endif
);

`ifdef HIT_HASH_CAPTURE_EN
    localparam int ENTRY_W = 544;
`else
    localparam int ENTRY_W = 32;
`endif

    logic               s1_hit;
    skein_nonce_t       s1_nonce;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [FIFO_AW:0]   fifo_count_unused;
    logic               pop;
    logic               drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hit   <= 1'b0;
            s1_nonce <= '0;
        end else begin
            s1_hit <= hash_vld && (hash[511:448] < target);
            if (hash_vld) begin
                s1_nonce <= nonce_origin(nonce, NONCE_LAG);
            end
        end
    end

`ifdef HIT_HASH_CAPTURE_EN
    skein_hash_t s1_hash;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hash <= '0;
        end else if (hash_vld) begin
            s1_hash <= hash;
        end
    end

    assign push_data = {s1_hash, s1_nonce};
    assign out_hash  = head[543:32];
`else
    logic [447:0] hash_low_unused;

    assign hash_low_unused = hash[447:0];
    assign push_data       = s1_nonce;
`endif

    assign out_vld   = !fifo_empty;
    assign out_nonce = head[31:0];
    assign pop       = out_vld && out_rdy;
    // A full FIFO still takes the hit when the head leaves in the same cycle.
    assign drop      = s1_hit && fifo_full && !pop;

    skein_hit_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s1_hit),
        .push_data (push_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count_unused),
        .head      (head)
    );

    // A hit in the same cycle as clr wins: the counter restarts at one, not zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (s1_hit) begin
                hit_cnt <= clr ? 32'd1 : hit_cnt + 32'd1;
            end else if (clr) begin
                hit_cnt <= '0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_skein_hit_filter.sv
// Directed bench for skein_hit_filter in its default build (no hash capture).
module tb_skein_hit_filter;
    import skein_pkg::*;

    localparam logic [63:0] TGT     = 64'h0000_0100_0000_0000;
    localparam logic [63:0] TOP_HIT = 64'h0000_00FF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic [63:0]  target;
    logic         hash_vld;
    skein_hash_t  hash;
    skein_nonce_t nonce;
    logic [31:0]  hit_cnt;
    logic         overflow;
    logic         out_vld;
    logic         out_rdy;
    skein_nonce_t out_nonce;

    logic [31:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    skein_hit_filter dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .target    (target),
        .hash_vld  (hash_vld),
        .hash      (hash),
        .nonce     (nonce),
        .hit_cnt   (hit_cnt),
        .overflow  (overflow),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_nonce (out_nonce)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one hash/nonce pair for a single edge; back-to-back calls give consecutive valids.
    task automatic hash_in(input logic [63:0] top, input logic [31:0] n);
        hash_vld        = 1'b1;
        hash            = '0;
        hash[511:448]   = top;
        hash[31:0]      = $urandom;
        hash[287:256]   = $urandom;
        nonce           = n;
        tick();
        hash_vld        = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            out_rdy = 1'b1;
            check("drain_vld", {63'd0, out_vld}, 64'd1);
            check("drain_nonce", {32'd0, out_nonce}, {32'd0, exp_q.pop_front()});
            tick();
        end
        out_rdy = 1'b0;
        check("drain_empty", {63'd0, out_vld}, 64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        clr      = 1'b0;
        target   = TGT;
        hash_vld = 1'b0;
        hash     = '0;
        nonce    = '0;
        out_rdy  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_vld", {63'd0, out_vld}, 64'd0);
        check("rst_out_nonce", {32'd0, out_nonce}, 64'd0);
        check("rst_hit_cnt", {32'd0, hit_cnt}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);

        // basic hit, two-edge latency, consumer ready
        out_rdy = 1'b1;
        hash_in(TOP_HIT, 32'h0000_1000);
        check("basic_vld_early", {63'd0, out_vld}, 64'd0);
        tick();
        check("basic_vld", {63'd0, out_vld}, 64'd1);
        check("basic_nonce", {32'd0, out_nonce}, 64'h0FDA);
        check("basic_hit_cnt", {32'd0, hit_cnt}, 64'd1);
        tick();
        check("basic_popped", {63'd0, out_vld}, 64'd0);
        out_rdy = 1'b0;

        // top word equal to target is not a hit
        hash_in(TGT, 32'h0000_2000);
        tick();
        check("eq_vld", {63'd0, out_vld}, 64'd0);
        check("eq_hit_cnt", {32'd0, hit_cnt}, 64'd1);

        // nonce wrap below zero
        hash_in(TOP_HIT, 32'h0000_0005);
        tick();
        check("wrap_hit_cnt", {32'd0, hit_cnt}, 64'd2);
        exp_q.push_back(32'hFFFF_FFDF);
        drain(1);

        // overflow: five hits into a four-entry FIFO with the consumer stalled
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_hit_cnt", {32'd0, hit_cnt}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            hash_in(TOP_HIT, 32'd100 + 32'(i));
            if (i < 4) exp_q.push_back(32'd62 + 32'(i));
        end
        check("ovf_not_yet", {63'd0, overflow}, 64'd0);
        check("ovf_cnt4", {32'd0, hit_cnt}, 64'd4);
        tick();
        check("ovf_set", {63'd0, overflow}, 64'd1);
        check("ovf_hit_cnt", {32'd0, hit_cnt}, 64'd5);
        tick();
        check("ovf_head_stable", {32'd0, out_nonce}, 64'd62);
        drain(4);
        check("ovf_sticky", {63'd0, overflow}, 64'd1);

        // full FIFO with a pop and a push on the same edge
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_overflow", {63'd0, overflow}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            hash_in(TOP_HIT, 32'd200 + 32'(i));
            exp_q.push_back(32'd162 + 32'(i));
        end
        out_rdy = 1'b1;
        check("fp_head", {32'd0, out_nonce}, {32'd0, exp_q.pop_front()});
        tick();
        out_rdy = 1'b0;
        check("fp_no_overflow", {63'd0, overflow}, 64'd0);
        check("fp_hit_cnt", {32'd0, hit_cnt}, 64'd5);
        drain(4);

        // reset with three entries queued
        hash_in(TOP_HIT, 32'h0000_0010);
        hash_in(TOP_HIT, 32'h0000_0011);
        hash_in(TOP_HIT, 32'h0000_0012);
        tick();
        check("pre_rst_vld", {63'd0, out_vld}, 64'd1);
        check("pre_rst_nonce", {32'd0, out_nonce}, 64'hFFFF_FFEA);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_vld", {63'd0, out_vld}, 64'd0);
        check("mid_rst_nonce", {32'd0, out_nonce}, 64'd0);
        check("mid_rst_hit_cnt", {32'd0, hit_cnt}, 64'd0);
        hash_in(TOP_HIT, 32'd300);
        tick();
        check("post_rst_hit_cnt", {32'd0, hit_cnt}, 64'd1);
        exp_q.push_back(32'd262);
        drain(1);

        // clr on the same edge as a hit reaching the counter
        hash_in(TOP_HIT, 32'd400);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_hit_cnt1", {32'd0, hit_cnt}, 64'd1);
        exp_q.push_back(32'd362);
        drain(1);

        // target extremes
        target = 64'd0;
        hash_in(64'd0, 32'd500);
        tick();
        check("tgt0_hit_cnt", {32'd0, hit_cnt}, 64'd1);
        check("tgt0_vld", {63'd0, out_vld}, 64'd0);
        target = '1;
        hash_in('1, 32'd501);
        tick();
        check("tgtmax_ones_cnt", {32'd0, hit_cnt}, 64'd1);
        hash_in(64'hFFFF_FFFF_FFFF_FFFE, 32'd502);
        tick();
        check("tgtmax_hit_cnt", {32'd0, hit_cnt}, 64'd2);
        exp_q.push_back(32'd464);
        drain(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/skein_hit_filter.md
Name: skein_hit_filter

Overview:
- Downstream consumer of the skein512 hashing core.
- Samples each 512-bit hash result and compares its most-significant 64-bit word against a difficulty target.
- Reconstructs the originating nonce from the pipeline lag and queues hits ("golden nonces") in a small FIFO for the host/UART controller.
- Sits between skein512 and the work-reporting logic; keeps the hashing pipeline free-running, with no backpressure into skein512.

Parameters:
- NONCE_LAG, 38: cycles between a nonce at skein512's nonce input and its hash at skein512's hash output; subtracted mod 2^32.
- FIFO_DEPTH, 4: hit FIFO entries; power of two, at least 2.
- FIFO_AW, $clog2(FIFO_DEPTH): FIFO pointer width (derived; do not override).

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: reset.
- clr, input, 1: synchronous clear of hit_cnt and overflow only; the FIFO is not affected.
- target, input, 64: difficulty threshold, unsigned.
- hash_vld, input, 1: hash/nonce pair valid this cycle; driven by the scan controller on the valid phase.
- hash, input, 512: skein512 hash output, byte order as produced.
- nonce, input, 32: nonce currently driven into skein512.
- out_vld, output, 1: FIFO head valid.
- out_rdy, input, 1: consumer accepts the head.
- out_nonce, output, 32: golden nonce at the FIFO head.
- out_hash, output, 512: hash at the FIFO head; present only with HIT_HASH_CAPTURE_EN.
- hit_cnt, output, 32: total hits detected, wrapping.
- overflow, output, 1: sticky flag, set when a hit was dropped.

Behaviour:
- Reset:
  - One clock and one reset; reset is synchronous and active-high (clk, rst).
  - rst empties the FIFO (pointers and count to 0) and clears the stage-1 valid.
  - After reset: out_vld=0, out_nonce=0, out_hash=0, hit_cnt=0, overflow=0.
  - rst asserted mid-operation discards all queued and in-flight hits; rst has priority over every other input.
- Stage 1 (registered), on hash_vld=1:
  - s1_hit <= (hash[511:448] < target), strict, unsigned 64-bit.
  - s1_nonce <= nonce - NONCE_LAG, 32-bit wrap; e.g. nonce=0x00000010 with lag 38 gives 0xFFFFFFEA.
  - With hash_vld=0: s1_hit <= 0.
- Stage 2, push, when s1_hit=1:
  - hit_cnt increments by 1, wrapping 0xFFFFFFFF to 0.
  - If the FIFO is not full, or a pop occurs in the same cycle, the entry is written.
  - Otherwise the entry is dropped and overflow <= 1.
- Pop: out_vld && out_rdy removes the head.
  - Simultaneous push and pop on a full FIFO: both succeed, count unchanged, no overflow.
  - Simultaneous push and pop on an empty FIFO cannot occur, since out_vld=0.
- Latency: hash_vld with a hit at edge N produces out_vld=1 after edge N+2 (registered compare, then FIFO write). Throughput is one hit per cycle.
- Output stability: out_nonce and out_hash are driven from the FIFO head register. They hold stable while out_vld=1 and out_rdy=0, and do not change until a pop.
- clr:
  - Clears hit_cnt and overflow.
  - If clr coincides with a hit: hit_cnt becomes 1 and overflow becomes 1 only if that hit is dropped. The event wins over the clear.
- target=0: no hits, since nothing is less than 0. target=0xFFFFFFFFFFFFFFFF: every hash hits except an all-ones top word.
- Pointers wrap modulo FIFO_DEPTH. full = (count==FIFO_DEPTH); empty = (count==0).

Optional Feature:
- Macro: HIT_HASH_CAPTURE_EN.
- Defined:
  - The FIFO entry is 544 bits (nonce plus hash).
  - Stage 1 also registers hash.
  - out_hash is a port carrying the stored hash of the head entry.
- Undefined:
  - The out_hash port and all hash storage are absent; entries are 32 bits.
  - All other behaviour is identical.

Decomposition:
- Package skein_pkg holds:
  - typedef skein_hash_t (logic [511:0]) and typedef skein_nonce_t (logic [31:0]);
  - localparam SKEIN_NONCE_LAG_DEFAULT = 38;
  - function nonce_origin(nonce, lag).
- One sub-module, skein_hit_fifo: a synchronous FIFO with parameterised width and depth, first-word-fall-through registered head, and push/pop/full/empty/count. It is shared with the future share-reporting path.

Test Plan:
- Basic hit:
  - Stimulus: rst then release; target=0x0000_0100_0000_0000; hash_vld=1 with hash[511:448]=0x0000_00FF_FFFF_FFFF and nonce=0x1000, out_rdy=1.
  - Required: out_vld=1 two edges later, out_nonce=0x0FDA, hit_cnt=1.
- Non-hit boundary: hash[511:448] equal to target (0x0000_0100_0000_0000).
  - Required: no FIFO write, hit_cnt stays 0.
- Nonce wrap: nonce=0x0000_0005 with a hit.
  - Required: out_nonce=0xFFFF_FFDF.
- Overflow:
  - Stimulus: out_rdy=0; 5 consecutive hits with nonces 100..104.
  - Required: 4 entries held; overflow=1 and hit_cnt=5 after the fifth. Draining yields 62, 63, 64, 65 in order.
- Full plus simultaneous pop: FIFO full, out_rdy=1 and a new hit in the same cycle.
  - Required: no overflow, count stays 4, order preserved.
- Reset and clear:
  - rst asserted with 3 entries queued: out_vld=0 next cycle, and subsequent hits restart from an empty FIFO.
  - clr coinciding with a hit: hit_cnt=1.
